// File: rtl/dmem_port_arbiter_pkg.sv
// rtl/dmem_port_arbiter_pkg.sv - shared types and constants for the data-memory port arbiter
package dmem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_NORMAL    = 2'd0,
        ARB_LOCK_PEND = 2'd1,
        ARB_LOCKED    = 2'd2
    } arb_state_e;

    localparam logic PORT_C = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int STARVE_W = 4;

endpackage

// File: rtl/dmem_port_arbiter_starve_ctr.sv
// rtl/dmem_port_arbiter_starve_ctr.sv - saturating wait counter for the debug port
module dmem_port_arbiter_starve_ctr
    import dmem_port_arbiter_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic at_max_o
);

    logic [STARVE_W-1:0] cnt_q;
    logic [STARVE_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != STARVE_W'(MAX))) begin
            cnt_d = cnt_q + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max_o = (cnt_q == STARVE_W'(MAX));

endmodule

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - shares single-port dmem between core (C) and debug/loader (D) masters
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 30,
    parameter int DMEM_WORDS = 8192,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              C_REQ,
    input  logic [3:0]        C_WSTB,
    input  logic [ADDR_W-1:0] C_ADDR,
    input  logic [31:0]       C_WDATA,
    output logic              C_GNT,
    output logic              C_STALL,
    output logic              C_RVALID,
    output logic [31:0]       C_RDATA,
    output logic              C_ERR,
    input  logic              D_REQ,
    input  logic [3:0]        D_WSTB,
    input  logic [ADDR_W-1:0] D_ADDR,
    input  logic [31:0]       D_WDATA,
    output logic              D_GNT,
    output logic              D_RVALID,
    output logic [31:0]       D_RDATA,
    output logic              D_ERR,
    input  logic              D_LOCK,
    output logic              D_LOCKED,
    output logic              M_EN,
    output logic [3:0]        M_WE,
    output logic [ADDR_W-1:0] M_ADDR,
    output logic [31:0]       M_WDATA,
    input  logic [31:0]       M_RDATA
);

    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DMEM_WORDS);

    arb_state_e        state_q;
    logic              d_locked_q;
    logic              acc_q;
    logic              rd_q;
    logic              tag_q;
    logic              oor_q;
    logic [31:0]       c_rdata_q;
    logic [31:0]       d_rdata_q;

    logic              at_max;
    logic              any_gnt;
    logic              sel_oor;
    logic              c_rd_ret;
    logic [ADDR_W-1:0] sel_addr;
    logic [3:0]        sel_wstb;
    logic [31:0]       sel_wdata;
    logic [31:0]       ret_data;

    dmem_port_arbiter_starve_ctr #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk_i    (CLK),
        .rstn_i   (RSTN),
        .clr_i    (D_GNT),
        .inc_i    (D_REQ & ~D_GNT),
        .at_max_o (at_max)
    );

    // Core keeps priority unless D has waited STARVE_MAX cycles or owns the memory.
    always_comb begin
        C_GNT = 1'b0;
        D_GNT = 1'b0;
        if ((state_q == ARB_LOCK_PEND) || ((state_q == ARB_LOCKED) && D_LOCK)) begin
            D_GNT = D_REQ;
        end else begin
            D_GNT = D_REQ & (at_max | ~C_REQ);
            C_GNT = C_REQ & ~D_GNT;
        end
    end

    assign any_gnt   = C_GNT | D_GNT;
    assign sel_addr  = D_GNT ? D_ADDR  : C_ADDR;
    assign sel_wstb  = D_GNT ? D_WSTB  : C_WSTB;
    assign sel_wdata = D_GNT ? D_WDATA : C_WDATA;
    assign sel_oor   = (sel_addr >= LIMIT);

    assign M_EN    = any_gnt & ~sel_oor;
    assign M_WE    = M_EN ? sel_wstb : 4'b0000;
    assign M_ADDR  = any_gnt ? sel_addr : '0;
    assign M_WDATA = any_gnt ? sel_wdata : 32'h0;

    assign C_STALL  = C_REQ & ~C_GNT;
    assign ret_data = oor_q ? 32'h0 : M_RDATA;
    assign C_RVALID = acc_q & rd_q & (tag_q == PORT_C);
    assign D_RVALID = acc_q & rd_q & (tag_q == PORT_D);
    assign C_ERR    = acc_q & oor_q & (tag_q == PORT_C);
    assign D_ERR    = acc_q & oor_q & (tag_q == PORT_D);
    assign C_RDATA  = C_RVALID ? ret_data : c_rdata_q;
    assign D_RDATA  = D_RVALID ? ret_data : d_rdata_q;
    assign D_LOCKED = d_locked_q;
    assign c_rd_ret = C_RVALID;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q    <= ARB_NORMAL;
            d_locked_q <= 1'b0;
            acc_q      <= 1'b0;
            rd_q       <= 1'b0;
            tag_q      <= PORT_C;
            oor_q      <= 1'b0;
            c_rdata_q  <= 32'h0;
            d_rdata_q  <= 32'h0;
        end else begin
            acc_q <= any_gnt;
            rd_q  <= (sel_wstb == 4'b0000);
            tag_q <= D_GNT ? PORT_D : PORT_C;
            oor_q <= sel_oor;
            if (C_RVALID) begin
                c_rdata_q <= ret_data;
            end
            if (D_RVALID) begin
                d_rdata_q <= ret_data;
            end
            // A core read returning this cycle must drain before the lock takes effect.
            case (state_q)
                ARB_NORMAL: begin
                    if (D_LOCK) begin
                        state_q <= ARB_LOCK_PEND;
                    end
                end
                ARB_LOCK_PEND: begin
                    if (!D_LOCK) begin
                        state_q <= ARB_NORMAL;
                    end else if (!c_rd_ret) begin
                        state_q    <= ARB_LOCKED;
                        d_locked_q <= 1'b1;
                    end
                end
                ARB_LOCKED: begin
                    if (!D_LOCK) begin
                        state_q    <= ARB_NORMAL;
                        d_locked_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= ARB_NORMAL;
                    d_locked_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - randomized scoreboard bench for dmem_port_arbiter
module tb_dmem_port_arbiter;

    localparam int AW    = 30;
    localparam int WORDS = 8192;
    localparam int SMAX  = 4;

    logic          CLK = 1'b0;
    logic          RSTN = 1'b0;
    logic          C_REQ = 1'b0;
    logic [3:0]    C_WSTB = '0;
    logic [AW-1:0] C_ADDR = '0;
    logic [31:0]   C_WDATA = '0;
    logic          C_GNT, C_STALL, C_RVALID, C_ERR;
    logic [31:0]   C_RDATA;
    logic          D_REQ = 1'b0;
    logic [3:0]    D_WSTB = '0;
    logic [AW-1:0] D_ADDR = '0;
    logic [31:0]   D_WDATA = '0;
    logic          D_GNT, D_RVALID, D_ERR;
    logic [31:0]   D_RDATA;
    logic          D_LOCK = 1'b0;
    logic          D_LOCKED;
    logic          M_EN;
    logic [3:0]    M_WE;
    logic [AW-1:0] M_ADDR;
    logic [31:0]   M_WDATA;
    logic [31:0]   M_RDATA = '0;

    always #5 CLK = ~CLK;

    dmem_port_arbiter #(.ADDR_W(AW), .DMEM_WORDS(WORDS), .STARVE_MAX(SMAX)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .C_REQ(C_REQ), .C_WSTB(C_WSTB), .C_ADDR(C_ADDR), .C_WDATA(C_WDATA),
        .C_GNT(C_GNT), .C_STALL(C_STALL), .C_RVALID(C_RVALID), .C_RDATA(C_RDATA), .C_ERR(C_ERR),
        .D_REQ(D_REQ), .D_WSTB(D_WSTB), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
        .D_GNT(D_GNT), .D_RVALID(D_RVALID), .D_RDATA(D_RDATA), .D_ERR(D_ERR),
        .D_LOCK(D_LOCK), .D_LOCKED(D_LOCKED),
        .M_EN(M_EN), .M_WE(M_WE), .M_ADDR(M_ADDR), .M_WDATA(M_WDATA), .M_RDATA(M_RDATA)
    );

    // Memory stub behind the arbiter and the reference image the model predicts from.
    logic [31:0] stub_mem [WORDS];
    logic [31:0] ref_mem  [WORDS];
    logic [31:0] stub_w;

    always @(posedge CLK) begin
        if (M_EN) begin
            if (M_WE == 4'b0000) begin
                M_RDATA <= stub_mem[M_ADDR[12:0]];
            end else begin
                stub_w = stub_mem[M_ADDR[12:0]];
                for (int b = 0; b < 4; b++) if (M_WE[b]) stub_w[8*b +: 8] = M_WDATA[8*b +: 8];
                stub_mem[M_ADDR[12:0]] <= stub_w;
            end
        end
    end

    int cycle = 0;
    always @(posedge CLK) cycle <= cycle + 1;

    typedef struct {
        int          due;
        logic        rd;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    rsp_t cq[$];
    rsp_t dq[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cycle);
        end
    endtask

    // Reference model: mode 0 normal, 1 lock pending, 2 locked; waitc counts D's unserved cycles.
    int          mode = 0;
    int          waitc = 0;
    int          c_last_rd = -10;
    logic        c_taken = 1'b0;
    logic        d_taken = 1'b0;
    logic        ec, ed, eoor, eret;
    logic [AW-1:0] ea;
    logic [3:0]  ews;
    logic [31:0] ewd, mw;
    rsp_t        er;

    always @(negedge CLK) begin
        if (mode == 1 || (mode == 2 && D_LOCK)) begin
            ec = 1'b0;
            ed = D_REQ;
        end else begin
            ed = D_REQ && (!C_REQ || waitc >= SMAX);
            ec = C_REQ && !ed;
        end
        ea   = ed ? D_ADDR  : C_ADDR;
        ews  = ed ? D_WSTB  : C_WSTB;
        ewd  = ed ? D_WDATA : C_WDATA;
        eoor = (ea >= AW'(WORDS));
        eret = (c_last_rd == cycle - 1);
        chk("c_gnt", 64'(C_GNT), 64'(ec));
        chk("d_gnt", 64'(D_GNT), 64'(ed));
        chk("c_stall", 64'(C_STALL), 64'(C_REQ && !ec));
        chk("d_locked", 64'(D_LOCKED), 64'(mode == 2));
        chk("m_en", 64'(M_EN), 64'((ec || ed) && !eoor));
        if ((ec || ed) && !eoor) begin
            chk("m_addr", 64'(M_ADDR), 64'(ea));
            chk("m_we", 64'(M_WE), 64'(ews));
            if (ews != 4'b0000) chk("m_wdata", 64'(M_WDATA), 64'(ewd));
        end
        c_taken = ec;
        d_taken = ed;
        if (!RSTN) begin
            mode = 0;
            waitc = 0;
            c_last_rd = -10;
            cq.delete();
            dq.delete();
        end else begin
            if (ec || ed) begin
                if (ews == 4'b0000 || eoor) begin
                    er.due  = cycle + 1;
                    er.rd   = (ews == 4'b0000);
                    er.err  = eoor;
                    er.data = eoor ? 32'h0 : ref_mem[ea[12:0]];
                    if (ed) dq.push_back(er); else cq.push_back(er);
                end else begin
                    mw = ref_mem[ea[12:0]];
                    for (int b = 0; b < 4; b++) if (ews[b]) mw[8*b +: 8] = ewd[8*b +: 8];
                    ref_mem[ea[12:0]] = mw;
                end
                if (ec && ews == 4'b0000) c_last_rd = cycle;
            end
            if (ed) waitc = 0;
            else if (D_REQ && waitc < SMAX) waitc++;
            case (mode)
                0: if (D_LOCK) mode = 1;
                1: if (!D_LOCK) mode = 0; else if (!eret) mode = 2;
                default: if (!D_LOCK) mode = 0;
            endcase
        end
    end

    task automatic mon(input bit is_d, input logic v, input logic e, input logic [31:0] rd);
        rsp_t r;
        int   sz;
        string pn;
        pn = is_d ? "d" : "c";
        sz = is_d ? dq.size() : cq.size();
        if (sz > 0) r = is_d ? dq[0] : cq[0];
        if (sz > 0 && r.due < cycle) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_rsp_missing: got none expected response due cycle %0d", pn, r.due);
            if (is_d) r = dq.pop_front(); else r = cq.pop_front();
            sz--;
            if (sz > 0) r = is_d ? dq[0] : cq[0];
        end
        if (v || e) begin
            if (sz == 0 || r.due != cycle) begin
                n_cmp++;
                n_fail++;
                $display("FAIL %s_rsp_unexpected: got rvalid=%0b err=%0b expected none at cycle %0d", pn, v, e, cycle);
            end else begin
                if (is_d) r = dq.pop_front(); else r = cq.pop_front();
                chk({pn, "_rvalid"}, 64'(v), 64'(r.rd));
                chk({pn, "_err"}, 64'(e), 64'(r.err));
                if (r.rd) chk({pn, "_rdata"}, 64'(rd), 64'(r.data));
            end
        end
    endtask

    always @(negedge CLK) begin
        if (RSTN) begin
            mon(1'b0, C_RVALID, C_ERR, C_RDATA);
            mon(1'b1, D_RVALID, D_ERR, D_RDATA);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 7) == 0) return AW'(8190 + $urandom_range(0, 5));
        return AW'($urandom_range(0, 31));
    endfunction

    task automatic new_c();
        C_REQ   = ($urandom_range(0, 9) < 6);
        C_WSTB  = $urandom_range(0, 1) ? 4'b0000 : 4'($urandom_range(1, 15));
        C_ADDR  = rnd_addr();
        C_WDATA = $urandom;
    endtask

    task automatic new_d();
        D_REQ   = ($urandom_range(0, 9) < 5);
        D_WSTB  = $urandom_range(0, 1) ? 4'b0000 : 4'($urandom_range(1, 15));
        D_ADDR  = rnd_addr();
        D_WDATA = $urandom;
    endtask

    task automatic idle_inputs();
        C_REQ = 1'b0; C_WSTB = '0; C_ADDR = '0; C_WDATA = '0;
        D_REQ = 1'b0; D_WSTB = '0; D_ADDR = '0; D_WDATA = '0;
    endtask

    logic [31:0] orig;

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            orig = $urandom;
            stub_mem[i] = orig;
            ref_mem[i]  = orig;
        end
        RSTN = 1'b0;
        tick();
        tick();
        RSTN = 1'b1;
        @(negedge CLK);
        #1;
        chk("reset_flags", 64'({C_GNT, C_STALL, C_RVALID, C_ERR, D_GNT, D_RVALID, D_ERR, D_LOCKED, M_EN, M_WE}), 64'h0);
        chk("reset_rdata", {C_RDATA, D_RDATA}, 64'h0);
        chk("reset_maddr", {2'b00, M_ADDR, M_WDATA}, 64'h0);

        // Lone core read of word 0x10.
        tick();
        C_REQ = 1'b1; C_WSTB = 4'b0000; C_ADDR = AW'('h10);
        tick();
        C_REQ = 1'b0;
        tick();

        // Both ports requesting continuously: D wins every fifth cycle.
        C_REQ = 1'b1; C_ADDR = AW'(1);
        D_REQ = 1'b1; D_WSTB = 4'b0000; D_ADDR = AW'(2);
        repeat (15) tick();
        idle_inputs();
        tick();

        // Byte-lane write then readback.
        orig = ref_mem[32];
        C_REQ = 1'b1; C_WSTB = 4'b0010; C_ADDR = AW'('h20); C_WDATA = 32'hAABBCCDD;
        tick();
        C_WSTB = 4'b0000;
        tick();
        C_REQ = 1'b0;
        tick();
        tick();
        chk("byte_write_hold", 64'(C_RDATA), 64'({orig[31:16], 8'hCC, orig[7:0]}));

        // Lock requested during a core read, then a burst of locked debug reads.
        C_REQ = 1'b1; C_WSTB = 4'b0000; C_ADDR = AW'(5); D_LOCK = 1'b1;
        tick();
        C_ADDR = AW'(6);
        tick();
        for (int i = 0; i < 16; i++) begin
            D_REQ = 1'b1; D_WSTB = 4'b0000; D_ADDR = AW'(i + 64);
            tick();
        end
        D_REQ = 1'b0;
        D_LOCK = 1'b0;
        tick();
        idle_inputs();
        tick();

        // Out-of-range debug read.
        D_REQ = 1'b1; D_WSTB = 4'b0000; D_ADDR = AW'(8192);
        tick();
        D_REQ = 1'b0;
        tick();

        for (int i = 0; i < 3000; i++) begin
            if (c_taken || !C_REQ) new_c();
            if (d_taken || !D_REQ) new_d();
            if ($urandom_range(0, 39) == 0) D_LOCK = ~D_LOCK;
            tick();
        end
        idle_inputs();
        D_LOCK = 1'b0;
        repeat (3) tick();

        // Reset while locked with a debug read being granted.
        D_LOCK = 1'b1;
        repeat (3) tick();
        D_REQ = 1'b1; D_WSTB = 4'b0000; D_ADDR = AW'(3);
        RSTN = 1'b0;
        tick();
        RSTN = 1'b1;
        D_REQ = 1'b0;
        D_LOCK = 1'b0;
        @(negedge CLK);
        #1;
        chk("post_reset_flags", 64'({C_GNT, C_STALL, C_RVALID, C_ERR, D_GNT, D_RVALID, D_ERR, D_LOCKED, M_EN, M_WE}), 64'h0);
        chk("post_reset_rdata", {C_RDATA, D_RDATA}, 64'h0);
        repeat (4) tick();
        chk("queues_drained", 64'(cq.size() + dq.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
